// File: rtl/cache_pkg.sv
// Shared types and width helpers for the direct-mapped data cache.
// Pure definitions; no timing or flow-control behaviour of its own.
// Index/tag widths are derived from the instance's DATA_WIDTH/SETS via the helpers.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } cache_state_t;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SETS       = 16;
    localparam int DEF_IDX_W      = $clog2(DEF_SETS);
    localparam int DEF_TAG_W      = DEF_DATA_WIDTH - DEF_IDX_W - 2;

    function automatic int idxWidth(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tagWidth(input int dataWidth, input int sets);
        return dataWidth - $clog2(sets) - 2;
    endfunction

endpackage

// File: rtl/cache_array.sv
// Valid/tag/data register file for one-word lines: async read, single write port.
// Latency: read is combinational; a write is visible in the cycle after its edge.
// No backpressure; clear-all beats a same-edge write so a flushed fill ends invalid.
module cache_array #(
    parameter int SETS       = cache_pkg::DEF_SETS,
    parameter int IDX_W      = cache_pkg::DEF_IDX_W,
    parameter int TAG_W      = cache_pkg::DEF_TAG_W,
    parameter int DATA_WIDTH = cache_pkg::DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      rdIdx,
    output logic                  rdValid,
    output logic [TAG_W-1:0]      rdTag,
    output logic [DATA_WIDTH-1:0] rdData,
    input  logic                  wrEn,
    input  logic [IDX_W-1:0]      wrIdx,
    input  logic [TAG_W-1:0]      wrTag,
    input  logic [DATA_WIDTH-1:0] wrData,
    input  logic                  clearAll
);

    logic [SETS-1:0]       validQ;
    logic [TAG_W-1:0]      tagQ  [SETS];
    logic [DATA_WIDTH-1:0] dataQ [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validQ <= '0;
        end else if (clearAll) begin
            validQ <= '0;
        end else if (wrEn) begin
            validQ[wrIdx] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only trusted behind a valid bit.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagQ[wrIdx]  <= wrTag;
            dataQ[wrIdx] <= wrData;
        end
    end

    assign rdValid = validQ[rdIdx];
    assign rdTag   = tagQ[rdIdx];
    assign rdData  = dataQ[rdIdx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through, no-write-allocate data cache in front of backing memory.
// Latency: load hit 0 cycles; miss/store stall k cycles where memory acks in cycle k.
// Backpressure: StallM_o holds the pipeline until mem_ack_i; mem_* stay stable while mem_req_o.
module data_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SETS       = DEF_SETS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReadM_i,
    input  logic                  MemWriteM_i,
    input  logic [DATA_WIDTH-1:0] AddrM_i,
    input  logic [DATA_WIDTH-1:0] WriteDataM_i,
    input  logic                  FlushM_i,
    output logic [DATA_WIDTH-1:0] ReadDataM_o,
    output logic                  StallM_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [DATA_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int IDX_W = idxWidth(SETS);
    localparam int TAG_W = tagWidth(DATA_WIDTH, SETS);
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};

    cache_state_t          state;
    logic [DATA_WIDTH-1:0] capAddr;
    logic [DATA_WIDTH-1:0] capData;
    logic                  memReq;
    logic                  memWe;
    logic                  flushPend;

    logic                  isIdle;
    logic [IDX_W-1:0]      lookIdx;
    logic [TAG_W-1:0]      lookTag;
    logic                  rdValid;
    logic [TAG_W-1:0]      rdTag;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  hit;
    logic                  loadHit;
    logic                  wantStore;
    logic                  wantFill;
    logic                  ackNow;
    logic                  wrEn;
    logic [DATA_WIDTH-1:0] wrData;
    logic                  clearAll;

    assign isIdle = (state == IDLE);

    // One lookup port: the live address in IDLE, the captured one while a transaction is open.
    assign lookIdx = isIdle ? AddrM_i[IDX_W+1:2] : capAddr[IDX_W+1:2];
    assign lookTag = isIdle ? AddrM_i[DATA_WIDTH-1:IDX_W+2] : capAddr[DATA_WIDTH-1:IDX_W+2];
    assign hit     = rdValid && (rdTag == lookTag);

    assign wantStore = isIdle && MemWriteM_i;
    assign wantFill  = isIdle && MemReadM_i && !MemWriteM_i && !hit;
    assign loadHit   = isIdle && MemReadM_i && !MemWriteM_i && hit;
    assign ackNow    = !isIdle && mem_ack_i;

    assign StallM_o    = wantStore || wantFill || (!isIdle && !mem_ack_i);
    assign ReadDataM_o = (state == FILL && mem_ack_i) ? mem_rdata_i :
                         loadHit                      ? rdData      : '0;

    assign wrEn     = ackNow && ((state == FILL) || hit);
    assign wrData   = (state == FILL) ? mem_rdata_i : capData;
    assign clearAll = (isIdle && FlushM_i) || (ackNow && (flushPend || FlushM_i));

    cache_array #(
        .SETS       (SETS),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rdIdx    (lookIdx),
        .rdValid  (rdValid),
        .rdTag    (rdTag),
        .rdData   (rdData),
        .wrEn     (wrEn),
        .wrIdx    (capAddr[IDX_W+1:2]),
        .wrTag    (capAddr[DATA_WIDTH-1:IDX_W+2]),
        .wrData   (wrData),
        .clearAll (clearAll)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            capAddr   <= '0;
            capData   <= '0;
            flushPend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wantStore || wantFill) begin
                        state     <= wantStore ? WRITE : FILL;
                        memReq    <= 1'b1;
                        memWe     <= wantStore;
                        capAddr   <= AddrM_i & ALIGN_MASK;
                        capData   <= WriteDataM_i;
                        flushPend <= 1'b0;
                    end
                end
                default: begin
                    if (FlushM_i) begin
                        flushPend <= 1'b1;
                    end
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        memReq    <= 1'b0;
                        memWe     <= 1'b0;
                        flushPend <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign mem_req_o   = memReq;
    assign mem_we_o    = memWe;
    assign mem_addr_o  = capAddr;
    assign mem_wdata_o = capData;

endmodule

// File: tb/tb_data_cache.sv
// Randomised + directed bench for data_cache against a line-map/memory-map reference model.
module tb_data_cache;

    localparam int DW   = 32;
    localparam int SETS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd = 1'b0, wr = 1'b0, flush = 1'b0, ack = 1'b0;
    logic [DW-1:0] addr = '0, wdata = '0, memRdata = '0;
    logic [DW-1:0] rdOut, memAddr, memWdata;
    logic          stall, memReq, memWe;

    always #5 clk = ~clk;

    data_cache #(.DATA_WIDTH(DW), .SETS(SETS)) dut (
        .clk          (clk),
        .rst          (rst),
        .MemReadM_i   (rd),
        .MemWriteM_i  (wr),
        .AddrM_i      (addr),
        .WriteDataM_i (wdata),
        .FlushM_i     (flush),
        .ReadDataM_o  (rdOut),
        .StallM_o     (stall),
        .mem_req_o    (memReq),
        .mem_we_o     (memWe),
        .mem_addr_o   (memAddr),
        .mem_wdata_o  (memWdata),
        .mem_rdata_i  (memRdata),
        .mem_ack_i    (ack)
    );

    // Reference model: which word address each line holds, plus a sparse backing memory.
    bit            mValid [SETS];
    logic [DW-1:0] mAddr  [SETS];
    logic [DW-1:0] mData  [SETS];
    logic [DW-1:0] memArr [logic [DW-1:0]];
    bit            busy = 0, curWe = 0, flushPend = 0;
    logic [DW-1:0] curAddr = '0, curData = '0;

    logic          checkEn = 1'b0;
    logic          expStall, expReq, expWe, expRdValid;
    logic [DW-1:0] expAddr, expWdata, expRdata;

    int            nCmp = 0, nFail = 0;
    int            obsStall, obsReqCycles, obsTxn;
    logic [DW-1:0] obsTxnAddr, lastRead;
    logic          obsTxnWe;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] memRead(input logic [DW-1:0] a);
        if (memArr.exists(a)) return memArr[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic int idxOf(input logic [DW-1:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    function automatic void clearModel();
        for (int i = 0; i < SETS; i++) mValid[i] = 0;
    endfunction

    always @(negedge clk) begin
        if (checkEn) begin
            chk("stall", {31'b0, stall}, {31'b0, expStall});
            chk("mem_req", {31'b0, memReq}, {31'b0, expReq});
            if (expReq) begin
                chk("mem_we", {31'b0, memWe}, {31'b0, expWe});
                chk("mem_addr", memAddr, expAddr);
                if (expWe) chk("mem_wdata", memWdata, expWdata);
            end
            if (expRdValid) chk("read_data", rdOut, expRdata);
        end
        if (stall) obsStall++;
        if (memReq) obsReqCycles++;
        if (memReq && ack) begin
            obsTxn++;
            obsTxnAddr = memAddr;
            obsTxnWe   = memWe;
        end
        if (rd && !stall) lastRead = rdOut;
    end

    // One clock cycle: inputs already driven; sets expectations, then advances the model at the edge.
    task automatic cycle(input bit ackNow);
        int            i;
        logic [DW-1:0] wa;
        bit            hit, startTxn, fl;
        fl = flush;
        if (!busy) begin
            wa = addr & ~32'h3;
            i  = idxOf(wa);
            hit = mValid[i] && (mAddr[i] == wa);
            ack      = 1'($urandom_range(0, 1));
            memRdata = $urandom;
            startTxn   = wr || (rd && !hit);
            expReq     = 1'b0;
            expStall   = startTxn;
            expRdValid = rd && !wr && hit;
            expRdata   = mData[i];
            @(posedge clk);
            if (startTxn) begin
                busy = 1; curWe = wr; curAddr = wa; curData = wdata; flushPend = 0;
            end
            if (fl) clearModel();
        end else begin
            i = idxOf(curAddr);
            ack      = ackNow;
            memRdata = curWe ? $urandom : memRead(curAddr);
            expReq     = 1'b1;
            expWe      = curWe;
            expAddr    = curAddr;
            expWdata   = curData;
            expStall   = !ackNow;
            expRdValid = ackNow && !curWe && rd;
            expRdata   = memRdata;
            @(posedge clk);
            if (fl) flushPend = 1;
            if (ackNow) begin
                busy = 0;
                if (curWe) begin
                    memArr[curAddr] = curData;
                    if (mValid[i] && mAddr[i] == curAddr) mData[i] = curData;
                end else begin
                    mValid[i] = 1; mAddr[i] = curAddr; mData[i] = memRdata;
                end
                if (flushPend) clearModel();
            end
        end
        #1;
    endtask

    task automatic access(input bit r, input bit w, input logic [DW-1:0] a, input logic [DW-1:0] d,
                          input bit fl, input int lat, input bit flDuring);
        int k;
        rd = r; wr = w; addr = a; wdata = d; flush = fl;
        obsStall = 0; obsReqCycles = 0; obsTxn = 0;
        cycle(1'b0);
        k = 1;
        while (busy) begin
            flush = flDuring && ($urandom_range(0, 1) == 1);
            cycle(k >= lat);
            k++;
        end
        rd = 0; wr = 0; flush = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clearModel();
        memArr[32'h100] = 32'hDEAD_BEEF;
        #12;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_req", {31'b0, memReq}, 32'd0);
        chk("rst_we", {31'b0, memWe}, 32'd0);
        chk("rst_addr", memAddr, 32'd0);
        chk("rst_wdata", memWdata, 32'd0);
        chk("rst_rdata", rdOut, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        checkEn = 1'b1;

        // Cold load with ack on the third request cycle.
        access(1, 0, 32'h100, 0, 0, 3, 0);
        chk("cold_stall_cycles", obsStall, 32'd3);
        chk("cold_read", lastRead, 32'hDEAD_BEEF);
        chk("cold_txns", obsTxn, 32'd1);
        chk("cold_txn_addr", obsTxnAddr, 32'h100);
        chk("cold_txn_we", {31'b0, obsTxnWe}, 32'd0);

        access(1, 0, 32'h100, 0, 0, 1, 0);
        chk("hit_stall", obsStall, 32'd0);
        chk("hit_read", lastRead, 32'hDEAD_BEEF);
        chk("hit_req_cycles", obsReqCycles, 32'd0);

        access(0, 1, 32'h100, 32'h1234_5678, 0, 1, 0);
        chk("store_txns", obsTxn, 32'd1);
        chk("store_we", {31'b0, obsTxnWe}, 32'd1);
        access(1, 0, 32'h100, 0, 0, 1, 0);
        chk("store_hit_stall", obsStall, 32'd0);
        chk("store_hit_read", lastRead, 32'h1234_5678);

        // 0x200 shares index 0 with 0x100: a non-allocating store must not evict it.
        access(0, 1, 32'h200, 32'hCAFE_F00D, 0, 2, 0);
        access(1, 0, 32'h100, 0, 0, 1, 0);
        chk("noalloc_keep", obsStall, 32'd0);
        access(1, 0, 32'h200, 0, 0, 2, 0);
        chk("noalloc_miss", obsStall, 32'd2);
        chk("noalloc_read", lastRead, 32'hCAFE_F00D);
        access(1, 0, 32'h100, 0, 0, 1, 0);
        chk("evicted_miss", obsStall, 32'd1);
        access(1, 0, 32'h100 + 4 * SETS, 0, 0, 1, 0);
        chk("conflict_miss", obsStall, 32'd1);
        access(1, 0, 32'h100, 0, 0, 3, 0);
        chk("conflict_reload", obsStall, 32'd3);

        // Reset in the middle of a fill.
        rd = 1; wr = 0; addr = 32'h104; flush = 0;
        cycle(1'b0);
        checkEn = 1'b0;
        ack = 1'b0;
        chk("fill_req_up", {31'b0, memReq}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_req_drop", {31'b0, memReq}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; rd = 0;
        busy = 0; flushPend = 0; clearModel();
        checkEn = 1'b1;
        access(1, 0, 32'h104, 0, 0, 2, 0);
        chk("after_rst_104", obsStall, 32'd2);
        access(1, 0, 32'h100, 0, 0, 1, 0);
        chk("after_rst_100", obsStall, 32'd1);

        // Flush in IDLE invalidates everything.
        access(1, 0, 32'h100, 0, 0, 1, 0);
        chk("pre_flush_hit", obsStall, 32'd0);
        access(0, 0, 32'h0, 0, 1, 1, 0);
        access(1, 0, 32'h100, 0, 0, 2, 0);
        chk("flush_100", obsStall, 32'd2);
        access(1, 0, 32'h104, 0, 0, 1, 0);
        chk("flush_104", obsStall, 32'd1);

        for (int n = 0; n < 400; n++) begin
            int            op;
            logic [DW-1:0] a;
            bit            r, w, fl;
            op = int'($urandom_range(0, 9));
            a  = 32'h1000 + $urandom_range(0, 3) * (4 * SETS) + $urandom_range(0, 3) * 4 + $urandom_range(0, 3);
            r  = (op >= 2 && op <= 5) || op == 8;
            w  = (op == 6 || op == 7 || op == 8);
            fl = (op == 9) || ($urandom_range(0, 7) == 0);
            access(r, w, a, $urandom, fl, int'($urandom_range(1, 4)), $urandom_range(0, 7) == 0);
        end

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
